line_window_3x3: RTL and testbench

Assembles a sliding 3x3 pixel window from the three row taps produced by the double line buffer, for the downstream convolution/filter kernel. Shifts one column of three vertically aligned pixels per accepted pixel, tracks image column and row, and flags only windows lying entirely inside the image. Sits between the line-buffer pair and the filter arithmetic, one per image pipeline.

---
 rtl/line_window_3x3_pkg.sv | 17 +
 rtl/line_window_3x3_pixel_xy_counter.sv | 54 +++++
 rtl/line_window_3x3.sv | 84 ++++++++
 tb/tb_line_window_3x3.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/line_window_3x3_pkg.sv
// Shared defaults and window indexing helper for the 3x3 window pipeline.
//   PIX_W_DEF / IMG_W_DEF / IMG_H_DEF : default pixel width and image size
//   win_off(pix_w, r, c)              : bit offset of window element (r,c)
package line_window_3x3_pkg;

  localparam int unsigned PIX_W_DEF = 8;
  localparam int unsigned IMG_W_DEF = 128;
  localparam int unsigned IMG_H_DEF = 128;

  // r=0 is the oldest row, c=0 the oldest column
  function automatic int unsigned win_off(input int unsigned pix_w,
                                          input int unsigned r,
                                          input int unsigned c);
    return pix_w * (3 * r + c);
  endfunction

endpackage

// File: rtl/line_window_3x3_pixel_xy_counter.sv
// Image column/row counter with wrap, synchronous clear and last-pixel flag.
//   clk, rst      : clock, async active-low reset
//   clear         : force position to (0,0) before this cycle's advance
//   advance       : one pixel accepted this cycle
//   col_c, row_c  : position of the pixel presented this cycle (after clear)
//   last_c        : that pixel is the final pixel of the frame
module pixel_xy_counter #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       advance,
  output logic [$clog2(IMG_W)-1:0]   col_c,
  output logic [$clog2(IMG_H)-1:0]   row_c,
  output logic                       last_c
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          col_end;
  logic          row_end;

  // clear acts before the increment so a simultaneous pixel is (0,0)
  assign col_c   = clear ? '0 : col_q;
  assign row_c   = clear ? '0 : row_q;
  assign col_end = (col_c == CW'(IMG_W - 1));
  assign row_end = (row_c == RW'(IMG_H - 1));
  assign last_c  = col_end && row_end;

  // position registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (advance) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= row_end ? '0 : row_c + RW'(1);
      end else begin
        col_q <= col_c + CW'(1);
        row_q <= row_c;
      end
    end else if (clear) begin
      col_q <= '0;
      row_q <= '0;
    end
  end

endmodule

// File: rtl/line_window_3x3.sv
// Sliding 3x3 window assembled from three vertically aligned row taps.
//   clk, rst            : clock, async active-low reset
//   start_i             : frame restart (pixel this cycle becomes (0,0))
//   valid_i             : a pixel column is present on data*_i
//   data0_i/1_i/2_i     : current line, one above, two above
//   window_o            : element (r,c) at [PIX_W*(3r+c) +: PIX_W]
//   win_valid_o         : window_o lies fully inside the image
//   col_o, row_o        : window centre, held between valid windows
//   frame_done_o        : last pixel of the frame accepted
module line_window_3x3
  import line_window_3x3_pkg::*;
#(
  parameter int unsigned IMG_W = IMG_W_DEF,
  parameter int unsigned IMG_H = IMG_H_DEF,
  parameter int unsigned PIX_W = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     valid_i,
  input  logic [PIX_W-1:0]         data0_i,
  input  logic [PIX_W-1:0]         data1_i,
  input  logic [PIX_W-1:0]         data2_i,
  output logic [9*PIX_W-1:0]       window_o,
  output logic                     win_valid_o,
  output logic [$clog2(IMG_W)-1:0] col_o,
  output logic [$clog2(IMG_H)-1:0] row_o,
  output logic                     frame_done_o
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned P  = PIX_W;

  logic [CW-1:0]      cur_col;
  logic [RW-1:0]      cur_row;
  logic               last_c;
  logic               win_ok_c;
  logic [9*P-1:0]     window_next;

  pixel_xy_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_xy (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_i),
    .advance (valid_i),
    .col_c   (cur_col),
    .row_c   (cur_row),
    .last_c  (last_c)
  );

  // per row: drop oldest column, new pixel becomes c2 (row 0 takes data2)
  assign window_next = {data0_i, window_o[9*P-1:7*P],
                        data1_i, window_o[6*P-1:4*P],
                        data2_i, window_o[3*P-1:P]};

  // cols/rows 0 and 1 of each line never complete a window, which also
  // keeps stale columns from the previous line out of valid beats
  assign win_ok_c = valid_i && (cur_col >= CW'(2)) && (cur_row >= RW'(2));

  // window shift array and registered status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      window_o     <= '0;
      win_valid_o  <= 1'b0;
      col_o        <= '0;
      row_o        <= '0;
      frame_done_o <= 1'b0;
    end else begin
      win_valid_o  <= win_ok_c;
      frame_done_o <= valid_i && last_c;
      if (valid_i) begin
        window_o <= window_next;
      end
      if (win_ok_c) begin
        col_o <= cur_col - CW'(1);
        row_o <= cur_row - RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_line_window_3x3.sv
// Scoreboard bench for line_window_3x3 with an 8x4 image.
module tb_line_window_3x3;
  import line_window_3x3_pkg::*;

  localparam int W = 8;
  localparam int H = 4;

  typedef struct packed {
    logic [71:0] win;
    logic [2:0]  col;
    logic [1:0]  row;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [7:0]  data0_i = '0;
  logic [7:0]  data1_i = '0;
  logic [7:0]  data2_i = '0;
  logic [71:0] window_o;
  logic        win_valid_o;
  logic [2:0]  col_o;
  logic [1:0]  row_o;
  logic        frame_done_o;

  int total = 0;
  int bad   = 0;
  int mx = 0, my = 0;
  logic exp_wv, exp_fd, obs_wv, obs_fd;
  beat_t exp_q[$];
  beat_t obs_q[$];

  line_window_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .valid_i(valid_i),
    .data0_i(data0_i), .data1_i(data1_i), .data2_i(data2_i),
    .window_o(window_o), .win_valid_o(win_valid_o), .col_o(col_o),
    .row_o(row_o), .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  // expected window around centre (cx,cy) for pixel value 16*row+col
  function automatic logic [71:0] exp_win(input int cx, input int cy);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w |= 72'(8'(16 * (cy - 1 + r) + (cx - 1 + c))) << win_off(8, r, c);
    return w;
  endfunction

  // drive one cycle, push expectations, capture observations
  task automatic drive(input logic v, input logic s);
    int x, y;
    exp_wv = 1'b0;
    exp_fd = 1'b0;
    if (s) begin mx = 0; my = 0; end
    x = mx; y = my;
    if (v) begin
      data0_i = 8'(16 * y + x);
      data1_i = 8'(16 * y + x - 16);
      data2_i = 8'(16 * y + x - 32);
      if (x >= 2 && y >= 2) begin
        exp_wv = 1'b1;
        exp_q.push_back('{win: exp_win(x - 1, y - 1), col: 3'(x - 1), row: 2'(y - 1)});
      end
      exp_fd = (x == W - 1) && (y == H - 1);
      if (x == W - 1) begin
        mx = 0;
        my = (y == H - 1) ? 0 : y + 1;
      end else begin
        mx = x + 1;
      end
    end else begin
      data0_i = 8'($urandom);
      data1_i = 8'($urandom);
      data2_i = 8'($urandom);
    end
    valid_i = v;
    start_i = s;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    valid_i = 1'b0;
    obs_wv = win_valid_o;
    obs_fd = frame_done_o;
    if (win_valid_o === 1'b1)
      obs_q.push_back('{win: window_o, col: col_o, row: row_o});
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({window_o, win_valid_o, col_o, row_o, frame_done_o} !== 78'd0) begin
      bad++;
      $display("FAIL reset_state got win=%h wv=%b col=%0d row=%0d fd=%b want all 0",
               window_o, win_valid_o, col_o, row_o, frame_done_o);
    end
    @(negedge clk);
    rst = 1'b1;
    mx = 0; my = 0;
    #1;
  endtask

  // one full frame, optionally with an idle cycle after every pixel
  task automatic test_frame(input bit toggle, input int tag);
    beat_t e, o, first_o, last_o;
    int beats = 0;
    logic [71:0] w_hold;
    logic [2:0]  c_hold;
    for (int i = 0; i < W * H; i++) begin
      drive(1'b1, 1'b0);
      total++;
      if (obs_wv !== exp_wv || obs_fd !== exp_fd) begin
        bad++;
        $display("FAIL frame%0d_flags px=%0d got wv=%b fd=%b want wv=%b fd=%b",
                 tag, i, obs_wv, obs_fd, exp_wv, exp_fd);
      end
      if (toggle) begin
        w_hold = window_o;
        c_hold = col_o;
        drive(1'b0, 1'b0);
        total++;
        if (obs_wv !== 1'b0 || obs_fd !== 1'b0 || window_o !== w_hold || col_o !== c_hold) begin
          bad++;
          $display("FAIL frame%0d_idle px=%0d got wv=%b fd=%b win=%h col=%0d want 0 0 %h %0d",
                   tag, i, obs_wv, obs_fd, window_o, col_o, w_hold, c_hold);
        end
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++;
        $display("FAIL frame%0d_missing got none want col=%0d row=%0d", tag, e.col, e.row);
      end else begin
        o = obs_q.pop_front();
        if (beats == 0) first_o = o;
        last_o = o;
        beats++;
        if (o !== e) begin
          bad++;
          $display("FAIL frame%0d_window got %h c%0d r%0d want %h c%0d r%0d",
                   tag, o.win, o.col, o.row, e.win, e.col, e.row);
        end
      end
    end
    total++;
    if (obs_q.size() != 0 || beats != 12) begin
      bad++;
      $display("FAIL frame%0d_count got beats=%0d extra=%0d want 12 0", tag, beats, obs_q.size());
    end
    obs_q.delete();
    total++;
    if (first_o.col !== 3'd1 || first_o.row !== 2'd1 || last_o.col !== 3'd6 || last_o.row !== 2'd2 ||
        first_o.win !== 72'h23_22_21_13_12_11_03_02_01 - 72'h01_01_01_01_01_01_01_01_01) begin
      bad++;
      $display("FAIL frame%0d_ends got first=(%0d,%0d) %h last=(%0d,%0d) want (1,1) 222120121110020100 (6,2)",
               tag, first_o.col, first_o.row, first_o.win, last_o.col, last_o.row);
    end
  endtask

  task automatic test_start();
    beat_t e, o;
    int k;
    for (int i = 0; i < 2 * W + 5; i++) drive(1'b1, 1'b0);
    // pixel (5,2) arrives with start and becomes (0,0)
    drive(1'b1, 1'b1);
    total++;
    if (obs_wv !== 1'b0 || obs_fd !== 1'b0) begin
      bad++;
      $display("FAIL start_pixel got wv=%b fd=%b want 0 0", obs_wv, obs_fd);
    end
    k = 0;
    obs_wv = 1'b0;
    while (obs_wv !== 1'b1 && k < 40) begin
      drive(1'b1, 1'b0);
      k++;
    end
    total++;
    if (k != 18 || col_o !== 3'd1 || row_o !== 2'd1) begin
      bad++;
      $display("FAIL start_first_window got after=%0d col=%0d row=%0d want 18 1 1", k, col_o, row_o);
    end
    while (!(mx == 0 && my == 0)) drive(1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++;
        $display("FAIL start_missing got none want col=%0d row=%0d", e.col, e.row);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL start_window got %h c%0d r%0d want %h c%0d r%0d",
                   o.win, o.col, o.row, e.win, e.col, e.row);
        end
      end
    end
    total++;
    if (obs_q.size() != 0) begin
      bad++;
      $display("FAIL start_extra got %0d want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2 * W + 5; i++) drive(1'b1, 1'b0);
    total++;
    if (obs_wv !== 1'b1 || col_o !== 3'd3) begin
      bad++;
      $display("FAIL areset_pre got wv=%b col=%0d want 1 3", obs_wv, col_o);
    end
    #3;
    rst = 1'b0;
    #1;
    total++;
    if ({window_o, win_valid_o, col_o, row_o, frame_done_o} !== 78'd0) begin
      bad++;
      $display("FAIL areset_clear got win=%h wv=%b col=%0d row=%0d fd=%b want all 0",
               window_o, win_valid_o, col_o, row_o, frame_done_o);
    end
    @(negedge clk);
    rst = 1'b1;
    mx = 0; my = 0;
    exp_q.delete();
    obs_q.delete();
    #1;
  endtask

  initial begin
    test_reset();
    test_frame(1'b0, 0);
    test_frame(1'b0, 1);
    test_frame(1'b1, 2);
    test_start();
    test_async_reset();
    test_frame(1'b0, 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
